// File: rtl/frame_reader_stream.sv
// Frame-buffer reader: raster-order reads from a 1-cycle-latency RAM, emitted as a
// ready/valid packet stream (sop/eop tagged) through a 2-entry skid buffer.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; no reads, busy=0
// STREAM | issuing reads 0..N-1 while buffer+in-flight read stay below 2
// DRAIN  | all reads issued; waiting for the eop handshake
module frame_reader_stream #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clock_clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sop_out,
  output logic                  eop_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [1:0]            count;
  logic                  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  buf_sop  [2];
  logic                  buf_eop  [2];
  logic                  inflight, inflight_sop, inflight_eop;
  logic                  pop, push, issue, last_issue;
  logic [2:0]            occ;

  assign valid_out  = (count != 2'd0);
  assign pop        = valid_out && ready_in;
  assign push       = inflight;
  assign data_out   = buf_data[rd_ptr];
  assign sop_out    = valid_out && buf_sop[rd_ptr];
  assign eop_out    = valid_out && buf_eop[rd_ptr];
  assign busy       = (state != ST_IDLE);

  // Occupancy counts the read already in flight, so a pop this cycle frees a slot.
  assign occ        = {1'b0, count} + {2'b00, inflight};
  assign issue      = (state == ST_STREAM) && (occ < (3'd2 + {2'b00, pop}));
  assign rd_en      = issue;
  assign last_issue = issue && (rd_addr == LAST_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (pop && eop_out) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      frame_done   <= 1'b0;
      rd_addr      <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done   <= (state == ST_DRAIN) && pop && eop_out;
      inflight     <= issue;
      inflight_sop <= issue && (rd_addr == '0);
      inflight_eop <= last_issue;
      if (state == ST_IDLE && start)
        rd_addr <= '0;
      else if (issue && !last_issue)
        rd_addr <= rd_addr + 1'b1;
    end
  end

  // Tags are captured alongside the pixel so they follow it through the buffer.
  always_ff @(posedge clock_clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_sop[i]  <= 1'b0;
        buf_eop[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= rd_data;
        buf_sop[wr_ptr]  <= inflight_sop;
        buf_eop[wr_ptr]  <= inflight_eop;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clock_clk) disable iff (!reset_n)
    !(push && !pop && count == 2'd2));

endmodule
